// File: rtl/sfx_pkg.sv
// sfx_pkg: shared types and constants for the sound-effect sequencer
package sfx_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;
  typedef struct packed {
    logic [3:0] tone;
    logic [1:0] dur;
    logic       last;
  } step_t;
  localparam int SFX_STEPS = 8;
  localparam logic [1:0] SFX_COIN   = 2'd0;
  localparam logic [1:0] SFX_WARBLE = 2'd1;
  localparam logic [1:0] SFX_RISE   = 2'd2;
  localparam logic [1:0] SFX_FALL   = 2'd3;
endpackage

// File: rtl/sfx_rom.sv
// sfx_rom: combinational note table indexed by effect and step
module sfx_rom
  import sfx_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [2:0] step,
  output step_t      entry
);
  // dur is stored as ticks-1; unused slots are marked last as a safety net
  always_comb begin
    entry = '{4'd0, 2'd0, 1'b1};
    case ({sel, step})
      {SFX_COIN, 3'd0}:   entry = '{4'd12, 2'd0, 1'b0};
      {SFX_COIN, 3'd1}:   entry = '{4'd8,  2'd0, 1'b0};
      {SFX_COIN, 3'd2}:   entry = '{4'd4,  2'd1, 1'b1};
      {SFX_WARBLE, 3'd0}: entry = '{4'd3,  2'd1, 1'b0};
      {SFX_WARBLE, 3'd1}: entry = '{4'd0,  2'd0, 1'b0};
      {SFX_WARBLE, 3'd2}: entry = '{4'd2,  2'd1, 1'b0};
      {SFX_WARBLE, 3'd3}: entry = '{4'd1,  2'd3, 1'b1};
      {SFX_RISE, 3'd0}:   entry = '{4'd5,  2'd0, 1'b0};
      {SFX_RISE, 3'd1}:   entry = '{4'd7,  2'd0, 1'b0};
      {SFX_RISE, 3'd2}:   entry = '{4'd9,  2'd0, 1'b0};
      {SFX_RISE, 3'd3}:   entry = '{4'd12, 2'd0, 1'b1};
      {SFX_FALL, 3'd0}:   entry = '{4'd9,  2'd1, 1'b0};
      {SFX_FALL, 3'd1}:   entry = '{4'd8,  2'd1, 1'b0};
      {SFX_FALL, 3'd2}:   entry = '{4'd7,  2'd1, 1'b0};
      {SFX_FALL, 3'd3}:   entry = '{4'd6,  2'd1, 1'b0};
      {SFX_FALL, 3'd4}:   entry = '{4'd5,  2'd1, 1'b0};
      {SFX_FALL, 3'd5}:   entry = '{4'd4,  2'd1, 1'b0};
      {SFX_FALL, 3'd6}:   entry = '{4'd3,  2'd1, 1'b0};
      {SFX_FALL, 3'd7}:   entry = '{4'd2,  2'd3, 1'b0};
      default:            entry = '{4'd0,  2'd0, 1'b1};
    endcase
  end
endmodule

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays short tone sequences from a ROM, one note per tick-timed step
module sfx_sequencer
  import sfx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] sound_sel,
  output logic [3:0] tone_idx,
  output logic       tone_en,
  output logic       busy,
  output logic       done
);
  state_t     state;
  logic [2:0] step;
  logic [2:0] dur_cnt;
  logic [1:0] sel;
  step_t      rom_q;
  sfx_rom u_rom (.sel(sel), .step(step), .entry(rom_q));
  // priority is stop > start > tick; step never wraps, the final slot forces completion
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      step     <= '0;
      dur_cnt  <= '0;
      sel      <= '0;
      tone_idx <= '0;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (stop) begin
      state    <= IDLE;
      tone_idx <= '0;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      sel   <= sound_sel;
      step  <= '0;
      state <= LOAD;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else
      case (state)
        LOAD: begin
          tone_idx <= rom_q.tone;
          tone_en  <= rom_q.tone != 4'd0;
          dur_cnt  <= {1'b0, rom_q.dur} + 3'd1;
          state    <= PLAY;
        end
        PLAY:
          if (tick) begin
            dur_cnt <= dur_cnt - 3'd1;
            if (dur_cnt == 3'd1) begin
              if (rom_q.last || step == 3'(SFX_STEPS - 1)) begin
                state    <= DONE;
                done     <= 1'b1;
                tone_idx <= '0;
                tone_en  <= 1'b0;
                busy     <= 1'b0;
              end else begin
                step  <= step + 3'd1;
                state <= LOAD;
              end
            end
          end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: doc/sfx_sequencer.md
SFX_SEQUENCER -- requirements
Module: sfx_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: tick  in  1  one-cycle pulse from the short one-second counter; timebase for note duration.
REQ-004 SHALL have ports: start  in  1  one-cycle request to play an effect.
REQ-005 SHALL have ports: stop  in  1  one-cycle abort request.
REQ-006 SHALL have ports: sound_sel  in  2  effect select, sampled only when start is accepted.
REQ-007 SHALL have ports: tone_idx  out  4  note index to the tone generator; 0 = rest.
REQ-008 SHALL have ports: tone_en  out  1  tone generator enable.
REQ-009 SHALL have ports: busy  out  1  effect in progress.
REQ-010 SHALL have ports: done  out  1  one-cycle pulse on natural completion.

Function
REQ-011 SHALL register all outputs; no combinational path from any input to any output.
REQ-012 SHALL implement the FSM states IDLE, LOAD, PLAY, DONE.
REQ-013 SHALL use a 3-bit step counter and a 3-bit duration counter.
REQ-014 SHALL store each ROM entry as: tone 4b, dur 2b (ticks-1, so 1..4 ticks), last 1b.
REQ-015 SHALL hold this ROM content: effect 0 = (12,1),(8,1),(4,2,last).
REQ-016 SHALL hold this ROM content: effect 1 = (3,2),(0,1),(2,2),(1,4,last).
REQ-017 SHALL hold this ROM content: effect 2 = (5,1),(7,1),(9,1),(12,1,last).
REQ-018 SHALL hold this ROM content: effect 3 = (9,2),(8,2),(7,2),(6,2),(5,2),(4,2),(3,2),(2,4), with no last flag.
REQ-019 SHALL, in IDLE, on start=1: latch sound_sel, clear step, go to LOAD, and assert busy from the next cycle.
REQ-020 SHALL, in LOAD (exactly one cycle): read ROM[sel][step], write tone_idx=tone, write tone_en=(tone!=0), load dur counter = dur+1, go to PLAY; a tick arriving in LOAD is ignored.
REQ-021 SHALL make the first tone visible 2 cycles after start is accepted.
REQ-022 SHALL, in PLAY, decrement the dur counter on each tick.
REQ-023 SHALL, in PLAY, on a tick with counter==1 and (last=1 or step==7): go to DONE.
REQ-024 SHALL, in PLAY, on a tick with counter==1 otherwise: increment step and go to LOAD; tone_idx and tone_en hold their values through LOAD.
REQ-025 SHALL, in DONE (one cycle): assert done=1, tone_en=0, tone_idx=0, busy=0, then go to IDLE.
REQ-026 SHALL apply input priority stop > start > tick.
REQ-027 SHALL, on stop in any state: go to IDLE next cycle with tone_en=0, tone_idx=0, busy=0, and no done pulse.
REQ-028 SHALL, on start in LOAD/PLAY/DONE without stop: restart by latching the new sound_sel, setting step=0, going to LOAD, and suppressing done.
REQ-029 SHALL keep busy=1 in LOAD and PLAY, including during rest steps (tone_en=0).
REQ-030 SHALL never wrap the step counter from 7 to 0; completion at step 7 is forced.

Reset
REQ-031 SHALL, while reset=1, asynchronously force: state=IDLE, step=0, dur counter=0, sel=0, tone_idx=0, tone_en=0, busy=0, done=0.
REQ-032 SHALL take reset mid-effect to abort with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-033 SHALL declare the following in package sfx_pkg: state enum, step_t struct {tone, dur, last}, SFX_STEPS=8, and the four effect-number constants.
REQ-034 SHALL place the ROM in the combinational sub-module sfx_rom (inputs sel and step, output step_t), instantiated once.

Verification
REQ-035 SHALL cover: reset asserted mid-PLAY -> all outputs 0 immediately; no done pulse after release.
REQ-036 SHALL cover: start with sel=0, ticks 100 cycles apart -> tone_idx 12 for 1 tick, 8 for 1 tick, 4 for 2 ticks; done=1 for exactly one cycle, 1 cycle after the 4th tick; busy then 0.
REQ-037 SHALL cover: sel=3 -> 8 steps for 18 ticks total; DONE reached after step 7 without a last flag; step never returns to 0.
REQ-038 SHALL cover: sel=1 -> step 1 gives tone_idx=0 and tone_en=0 for 1 tick, with busy held at 1.
REQ-039 SHALL cover: start with sel=2 during sel=1 step 2 -> tone_idx=5 two cycles later, no done from the aborted effect; also, start and stop asserted in the same cycle -> IDLE, no tone.
REQ-040 SHALL cover: tick coincident with the LOAD cycle -> ignored; the step lasts dur+1 subsequent ticks.
